// File: rtl/seg7_scan4_if.sv
// Load port for seg7_scan4: valid/ready transfer of one 8-bit active-low
// segment code into a numbered digit slot.
//   load_valid  source -> sink   load request, held until accepted
//   load_ready  sink   -> source sink can accept this cycle
//   load_idx    source -> sink   target digit index (IDX_W bits)
//   load_seg7   source -> sink   active-low segment code, bit7 = dp
interface seg7_scan4_if #(
   parameter int unsigned IDX_W = 2
);
   logic             load_valid;
   logic             load_ready;
   logic [IDX_W-1:0] load_idx;
   logic [7:0]       load_seg7;

   modport master (
      output load_valid,
      output load_idx,
      output load_seg7,
      input  load_ready
   );

   modport slave (
      input  load_valid,
      input  load_idx,
      input  load_seg7,
      output load_ready
   );
endinterface

// File: rtl/seg7_scan4.sv
// seg7_scan4: multiplexed common-anode 7-segment display driver.
// Segment codes are written into a shadow buffer through a valid/ready
// port and copied to the display buffer in one shot at the end of each
// frame, so a frame never shows a mix of old and new codes. Each digit
// slot lasts PRESCALE clocks; the first BLANK clocks of a slot keep all
// digits off to suppress ghosting while the anode switches.
// Ports:
//   t_Clock     system clock, rising edge
//   rst         asynchronous active-high reset
//   load        seg7_scan4_if.slave load port
//   dig_en      active-low digit enables, bit i = digit i
//   seg_out     active-low segments for the enabled digit
//   frame_tick  one-cycle pulse on the last clock of a frame (commit cycle)
module seg7_scan4 #(
   parameter int unsigned DIGITS   = 4,
   parameter int unsigned IDX_W    = 2,
   parameter int unsigned PRESCALE = 4,
   parameter int unsigned BLANK    = 1
) (
   input  logic              t_Clock,
   input  logic              rst,
   seg7_scan4_if.slave       load,
   output logic [DIGITS-1:0] dig_en,
   output logic [7:0]        seg_out,
   output logic              frame_tick
);

   localparam int unsigned PCNT_W = $clog2(PRESCALE);
   localparam int unsigned DPTR_W = $clog2(DIGITS);

   localparam logic [PCNT_W-1:0] PCNT_LAST  = PCNT_W'(PRESCALE - 1);
   localparam logic [PCNT_W-1:0] PCNT_BLANK = PCNT_W'(BLANK);
   localparam logic [DPTR_W-1:0] DPTR_LAST  = DPTR_W'(DIGITS - 1);

   logic [PCNT_W-1:0] pcnt;
   logic [DPTR_W-1:0] dptr;
   logic [7:0]        shadow [DIGITS];
   logic [7:0]        active [DIGITS];

   logic slot_end;
   logic commit;
   logic load_fire;

   // Slot / frame boundary decode; loads are refused in the commit cycle
   always_comb begin
      slot_end  = (pcnt == PCNT_LAST);
      commit    = slot_end && (dptr == DPTR_LAST);
      load_fire = load.load_valid && !commit;
   end

   // Scan position: slot counter and digit pointer
   always_ff @(posedge t_Clock or posedge rst) begin
      if (rst) begin
         pcnt <= '0;
         dptr <= '0;
      end else if (slot_end) begin
         pcnt <= '0;
         dptr <= (dptr == DPTR_LAST) ? '0 : dptr + DPTR_W'(1);
      end else begin
         pcnt <= pcnt + PCNT_W'(1);
      end
   end

   // Shadow write port and frame-boundary commit into the display buffer.
   // An index with no matching digit matches no entry, so its data is dropped.
   always_ff @(posedge t_Clock or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < int'(DIGITS); i++) begin
            shadow[i] <= 8'hFF;
            active[i] <= 8'hFF;
         end
      end else begin
         for (int i = 0; i < int'(DIGITS); i++) begin
            if (load_fire && (load.load_idx == IDX_W'(i))) begin
               shadow[i] <= load.load_seg7;
            end
            if (commit) begin
               active[i] <= shadow[i];
            end
         end
      end
   end

   // Display decode straight from the scan state; reset forces a dark display
   always_comb begin
      dig_en          = '1;
      seg_out         = 8'hFF;
      frame_tick      = 1'b0;
      load.load_ready = 1'b1;
      if (!rst) begin
         frame_tick      = commit;
         load.load_ready = !commit;
         if (pcnt >= PCNT_BLANK) begin
            for (int i = 0; i < int'(DIGITS); i++) begin
               if (dptr == DPTR_W'(i)) begin
                  dig_en[i] = 1'b0;
                  seg_out   = active[i];
               end
            end
         end
      end
   end

endmodule
